// File: rtl/reg_access_ctrl_if.sv
// Host/register-bank signal bundle for reg_access_ctrl.
// The master side is the host plus register bank; the slave side is the controller.
interface reg_access_ctrl_if #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8
);
  logic                       sel_en;
  logic                       wr_rd_s;
  logic [ADDR_W-1:0]          addr;
  logic [DATA_W-1:0]          wdata;
  logic [NUM_REGS*DATA_W-1:0] reg_rdata;
  logic [NUM_REGS-1:0]        wr_en;
  logic [DATA_W-1:0]          wr_data;
  logic [DATA_W-1:0]          rd_data;
  logic                       ack;
  logic                       err;
  logic                       busy;

  modport master (
    output sel_en, wr_rd_s, addr, wdata, reg_rdata,
    input  wr_en, wr_data, rd_data, ack, err, busy
  );

  modport slave (
    input  sel_en, wr_rd_s, addr, wdata, reg_rdata,
    output wr_en, wr_data, rd_data, ack, err, busy
  );
endinterface

// File: rtl/reg_access_ctrl.sv
// Register-access controller: one read or write per select assertion, one-hot
// write strobes, muxed read-back with optional wait states, and range errors.
module reg_access_ctrl #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int RD_WAIT  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  reg_access_ctrl_if.slave  host_io
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, RELEASE} state_e;

  localparam logic [ADDR_W:0] NumRegsExt = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [7:0]      RdWaitCnt  = 8'(RD_WAIT);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic                inErr, latchedErr;
  logic [NUM_REGS-1:0] inOneHot;
  logic [DATA_W-1:0]   rdSel;

  // Full-width unsigned compare so high address bits are never aliased away.
  assign inErr      = ({1'b0, host_io.addr} >= NumRegsExt);
  assign latchedErr = ({1'b0, addr_q} >= NumRegsExt);

  always_comb begin
    inOneHot = '0;
    rdSel    = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      inOneHot[i] = (host_io.addr == ADDR_W'(i));
      if (addr_q == ADDR_W'(i)) rdSel = host_io.reg_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_en_q   <= '0;
      wr_data_q <= '0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (host_io.sel_en) state_d = host_io.wr_rd_s ? WRITE : READ;
      WRITE:   state_d = RELEASE;
      READ:    if (cnt_q == '0) state_d = RELEASE;
      RELEASE: if (!host_io.sel_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ack/err/wr_en default low so each is a single-cycle pulse.
  always_comb begin
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    wr_en_d   = '0;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    busy_d    = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (host_io.sel_en) begin
          addr_d = host_io.addr;
          if (host_io.wr_rd_s) begin
            if (!inErr) begin
              wr_en_d   = inOneHot;
              wr_data_d = host_io.wdata;
            end
          end else begin
            cnt_d = RdWaitCnt;
          end
        end
      end
      WRITE: begin
        ack_d = 1'b1;
        err_d = latchedErr;
      end
      READ: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          rd_data_d = rdSel;
          ack_d     = 1'b1;
          err_d     = latchedErr;
        end
      end
      default: ;
    endcase
  end

  assign host_io.wr_en   = wr_en_q;
  assign host_io.wr_data = wr_data_q;
  assign host_io.rd_data = rd_data_q;
  assign host_io.ack     = ack_q;
  assign host_io.err     = err_q;
  assign host_io.busy    = busy_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Scoreboard bench for reg_access_ctrl: three instances with RD_WAIT 0, 3 and 5;
// stimulus pushes expected acks/strobes, a negedge monitor pops and compares.
module tb_reg_access_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         dut;
    bit         isRead;
    logic       err;
    logic [7:0] rd;
    int         cyc;
  } ack_t;

  typedef struct {
    int         dut;
    logic [3:0] en;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  ack_t ackQ[$];
  wr_t  wrQ[$];

  logic [2:0]  selEn = '0;
  logic [2:0]  wrRdS = '0;
  logic [7:0]  addrV[3];
  logic [7:0]  wdataV[3];
  logic [31:0] regRdata[3];

  wire [2:0] ackW, errW, busyW;
  wire [3:0] wrEnW[3];
  wire [7:0] wrDataW[3];
  wire [7:0] rdDataW[3];

  reg_access_ctrl_if #(.NUM_REGS(4), .DATA_W(8), .ADDR_W(8)) bus0();
  reg_access_ctrl_if #(.NUM_REGS(4), .DATA_W(8), .ADDR_W(8)) bus1();
  reg_access_ctrl_if #(.NUM_REGS(4), .DATA_W(8), .ADDR_W(8)) bus2();

  reg_access_ctrl #(.NUM_REGS(4), .DATA_W(8), .ADDR_W(8), .RD_WAIT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .host_io(bus0));
  reg_access_ctrl #(.NUM_REGS(4), .DATA_W(8), .ADDR_W(8), .RD_WAIT(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .host_io(bus1));
  reg_access_ctrl #(.NUM_REGS(4), .DATA_W(8), .ADDR_W(8), .RD_WAIT(5)) dut2 (
    .clk(clk), .rst_n(rst_n), .host_io(bus2));

  assign bus0.sel_en = selEn[0];
  assign bus0.wr_rd_s = wrRdS[0];
  assign bus0.addr = addrV[0];
  assign bus0.wdata = wdataV[0];
  assign bus0.reg_rdata = regRdata[0];
  assign ackW[0] = bus0.ack;
  assign errW[0] = bus0.err;
  assign busyW[0] = bus0.busy;
  assign wrEnW[0] = bus0.wr_en;
  assign wrDataW[0] = bus0.wr_data;
  assign rdDataW[0] = bus0.rd_data;

  assign bus1.sel_en = selEn[1];
  assign bus1.wr_rd_s = wrRdS[1];
  assign bus1.addr = addrV[1];
  assign bus1.wdata = wdataV[1];
  assign bus1.reg_rdata = regRdata[1];
  assign ackW[1] = bus1.ack;
  assign errW[1] = bus1.err;
  assign busyW[1] = bus1.busy;
  assign wrEnW[1] = bus1.wr_en;
  assign wrDataW[1] = bus1.wr_data;
  assign rdDataW[1] = bus1.rd_data;

  assign bus2.sel_en = selEn[2];
  assign bus2.wr_rd_s = wrRdS[2];
  assign bus2.addr = addrV[2];
  assign bus2.wdata = wdataV[2];
  assign bus2.reg_rdata = regRdata[2];
  assign ackW[2] = bus2.ack;
  assign errW[2] = bus2.err;
  assign busyW[2] = bus2.busy;
  assign wrEnW[2] = bus2.wr_en;
  assign wrDataW[2] = bus2.wr_data;
  assign rdDataW[2] = bus2.rd_data;

  function automatic int waitOf(int d);
    return (d == 0) ? 0 : ((d == 1) ? 3 : 5);
  endfunction

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Issues a request at the next negedge; E0 is the following posedge (cyc+1).
  task automatic applyStimulus(int d, bit wr, logic [7:0] a, logic [7:0] wd,
                               bit expErr, logic [7:0] expRd, bit expectAck);
    @(negedge clk);
    if (expectAck) begin
      ackQ.push_back('{dut: d, isRead: !wr, err: expErr, rd: expRd,
                       cyc: cyc + 2 + (wr ? 0 : waitOf(d))});
      if (wr && !expErr)
        wrQ.push_back('{dut: d, en: 4'(1 << a), data: wd, cyc: cyc + 1});
    end
    wrRdS[d] = wr;
    addrV[d] = a;
    wdataV[d] = wd;
    selEn[d] = 1'b1;
  endtask

  task automatic holdFor(int d, int n);
    repeat (n) @(negedge clk);
    selEn[d] = 1'b0;
  endtask

  // Monitor: every ack or write strobe must match the head of its queue.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (ackW[d]) begin
        if (ackQ.size() == 0) begin
          checkOutput("spurious_ack", 32'(ackW[d]), 0);
        end else begin
          ack_t e;
          e = ackQ.pop_front();
          checkOutput("ack_dut", d, e.dut);
          checkOutput("ack_cycle", cyc, e.cyc);
          checkOutput("ack_err", 32'(errW[d]), 32'(e.err));
          if (e.isRead) checkOutput("rd_data", 32'(rdDataW[d]), 32'(e.rd));
        end
      end else if (errW[d]) begin
        checkOutput("err_no_ack", 32'(errW[d]), 0);
      end
      if (wrEnW[d] != '0) begin
        if (wrQ.size() == 0) begin
          checkOutput("spurious_wr_en", 32'(wrEnW[d]), 0);
        end else begin
          wr_t w;
          w = wrQ.pop_front();
          checkOutput("wr_dut", d, w.dut);
          checkOutput("wr_cycle", cyc, w.cyc);
          checkOutput("wr_en", 32'(wrEnW[d]), 32'(w.en));
          checkOutput("wr_data", 32'(wrDataW[d]), 32'(w.data));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      addrV[d] = '0;
      wdataV[d] = '0;
      regRdata[d] = 32'h4433_2211;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput("rst_ack", 32'(ackW[d]), 0);
      checkOutput("rst_err", 32'(errW[d]), 0);
      checkOutput("rst_busy", 32'(busyW[d]), 0);
      checkOutput("rst_wr_en", 32'(wrEnW[d]), 0);
      checkOutput("rst_wr_data", 32'(wrDataW[d]), 0);
      checkOutput("rst_rd_data", 32'(rdDataW[d]), 0);
    end
    rst_n = 1'b1;

    $display("[TB] write addr 2, sel_en held past ack");
    applyStimulus(0, 1'b1, 8'h02, 8'hA5, 1'b0, 8'h00, 1'b1);
    holdFor(0, 5);

    $display("[TB] read addr 3, no wait states");
    applyStimulus(0, 1'b0, 8'h03, 8'h00, 1'b0, 8'h44, 1'b1);
    holdFor(0, 4);
    @(negedge clk);
    checkOutput("rd_hold", 32'(rdDataW[0]), 32'h44);
    checkOutput("busy_idle", 32'(busyW[0]), 0);

    $display("[TB] read addr 1 with 3 wait states, data changes mid-wait");
    applyStimulus(1, 1'b0, 8'h01, 8'h00, 1'b0, 8'h99, 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k <= 5) checkOutput("busy_wait", 32'(busyW[1]), 1);
      if (k == 3) regRdata[1][15:8] = 8'h99;
    end
    selEn[1] = 1'b0;

    $display("[TB] out-of-range write and read");
    applyStimulus(0, 1'b1, 8'h84, 8'hFF, 1'b1, 8'h00, 1'b1);
    holdFor(0, 3);
    checkOutput("rd_keep_after_wr", 32'(rdDataW[0]), 32'h44);
    applyStimulus(0, 1'b0, 8'h04, 8'h00, 1'b1, 8'h00, 1'b1);
    holdFor(0, 3);
    @(negedge clk);
    checkOutput("rd_err_zero", 32'(rdDataW[0]), 0);

    $display("[TB] held select then one-cycle gap");
    applyStimulus(0, 1'b1, 8'h01, 8'h3C, 1'b0, 8'h00, 1'b1);
    holdFor(0, 6);
    applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h11, 1'b1);
    holdFor(0, 3);

    $display("[TB] reset during a 5-wait read");
    applyStimulus(2, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_busy", 32'(busyW[2]), 0);
    checkOutput("rst_mid_ack", 32'(ackW[2]), 0);
    checkOutput("rst_mid_rd0", 32'(rdDataW[0]), 0);
    repeat (2) @(negedge clk);
    ackQ.push_back('{dut: 2, isRead: 1'b1, err: 1'b0, rd: 8'h11, cyc: cyc + 2 + waitOf(2)});
    rst_n = 1'b1;
    holdFor(2, 9);

    for (int i = 0; i < 20 && (ackQ.size() != 0 || wrQ.size() != 0); i++) @(negedge clk);
    checkOutput("drain_ack", ackQ.size(), 0);
    checkOutput("drain_wr", wrQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
